// File: rtl/bcdu_digit_reader.sv
// Reads one bcdu register digit by digit (COPY to scratch, then NUM_DIGITS shift-lefts)
// and presents a leading-zero-blanked display word to the 7-segment driver.
module bcdu_digit_reader #(
    parameter int         NUM_DIGITS   = 4,
    parameter int         ADDR_WIDTH   = 2,
    parameter int         SCRATCH_ADDR = 3,
    parameter logic [3:0] OPC_COPY     = 4'h1,
    parameter logic [3:0] OPC_SHL      = 4'h4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_src_addr,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic [NUM_DIGITS*4-1:0] o_digits,
    output logic                    o_bcdu_valid,
    output logic [15:0]             o_bcdu_instr,
    input  logic                    i_bcdu_ready,
    input  logic [3:0]              i_bcdu_digit,
    output logic [2:0]              o_dbg_state
);

    // Handshake: an instruction transfers on a cycle with o_bcdu_valid && i_bcdu_ready;
    // valid/instr are registered, held stable until transfer, and valid drops the cycle after.

    localparam int               W        = NUM_DIGITS * 4;
    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [3:0]       SCRATCH  = 4'(SCRATCH_ADDR);
    localparam logic [15:0]      SHL_WORD = {OPC_SHL, SCRATCH, 4'h0, 4'h1};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE_COPY = 3'd1,
        S_WAIT_COPY  = 3'd2,
        S_ISSUE_SHL  = 3'd3,
        S_WAIT_SHL   = 3'd4,
        S_FINISH     = 3'd5
    } state_t;

    state_t           state;
    logic             wait_first;
    logic             err_sticky;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     shadow;

    logic [3:0]       cap_digit;
    logic             cap_bad;
    logic [IDX_W-1:0] slot;
    logic [W-1:0]     shadow_cap;
    logic [15:0]      copy_word;

    assign o_dbg_state = state;

    // Leading zeros from the MSD become blank; the LSD always stays visible.
    function automatic logic [W-1:0] blank_leading(input logic [W-1:0] d);
        logic [W-1:0] r;
        logic         lead;
        r    = d;
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lead && d[i*4 +: 4] == 4'h0) begin
                r[i*4 +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

    always_comb begin
        cap_bad    = (i_bcdu_digit > 4'd9);
        cap_digit  = cap_bad ? 4'hF : i_bcdu_digit;
        slot       = LAST_IDX - idx;
        shadow_cap = shadow;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i == int'(slot)) begin
                shadow_cap[i*4 +: 4] = cap_digit;
            end
        end
        copy_word  = {OPC_COPY, SCRATCH, 4'(i_src_addr), 4'h0};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            wait_first   <= 1'b0;
            err_sticky   <= 1'b0;
            idx          <= '0;
            shadow       <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_digits     <= '1;
            o_bcdu_valid <= 1'b0;
            o_bcdu_instr <= 16'h0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        o_busy       <= 1'b1;
                        err_sticky   <= 1'b0;
                        idx          <= '0;
                        shadow       <= '0;
                        o_bcdu_valid <= 1'b1;
                        o_bcdu_instr <= copy_word;
                        state        <= S_ISSUE_COPY;
                    end
                end
                S_ISSUE_COPY: begin
                    if (i_bcdu_ready) begin
                        o_bcdu_valid <= 1'b0;
                        wait_first   <= 1'b1;
                        state        <= S_WAIT_COPY;
                    end
                end
                // The bcdu still shows ready for one cycle after accept, so that cycle is skipped.
                S_WAIT_COPY: begin
                    if (wait_first) begin
                        wait_first <= 1'b0;
                    end else if (i_bcdu_ready) begin
                        idx          <= '0;
                        o_bcdu_valid <= 1'b1;
                        o_bcdu_instr <= SHL_WORD;
                        state        <= S_ISSUE_SHL;
                    end
                end
                S_ISSUE_SHL: begin
                    if (i_bcdu_ready) begin
                        o_bcdu_valid <= 1'b0;
                        wait_first   <= 1'b1;
                        state        <= S_WAIT_SHL;
                    end
                end
                S_WAIT_SHL: begin
                    if (wait_first) begin
                        wait_first <= 1'b0;
                    end else if (i_bcdu_ready) begin
                        shadow <= shadow_cap;
                        if (cap_bad) begin
                            err_sticky <= 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            o_digits <= blank_leading(shadow_cap);
                            o_done   <= 1'b1;
                            o_err    <= err_sticky | cap_bad;
                            state    <= S_FINISH;
                        end else begin
                            idx          <= idx + 1'b1;
                            o_bcdu_valid <= 1'b1;
                            o_bcdu_instr <= SHL_WORD;
                            state        <= S_ISSUE_SHL;
                        end
                    end
                end
                S_FINISH: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    o_busy       <= 1'b0;
                    o_bcdu_valid <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcdu_digit_reader.sv
// Bench for bcdu_digit_reader: a small bcdu stand-in answers instructions, a scoreboard
// checks the instruction stream and every completed display word.
module tb_bcdu_digit_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  src = 2'd0;
    logic        busy, done, err, bcdu_valid, bcdu_ready;
    logic [15:0] digits, bcdu_instr;
    logic [3:0]  bcdu_digit;
    logic [2:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcdu_digit_reader dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_src_addr   (src),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_digits     (digits),
        .o_bcdu_valid (bcdu_valid),
        .o_bcdu_instr (bcdu_instr),
        .i_bcdu_ready (bcdu_ready),
        .i_bcdu_digit (bcdu_digit),
        .o_dbg_state  (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // ---------------- bcdu stand-in ----------------
    // Ready stays high right after accept with a stale digit; the real digit appears a cycle later.
    logic [15:0] regs [16];
    logic [15:0] scratch;
    logic        pend;
    logic [3:0]  pend_digit;
    int          shift_no;
    int          inject_at = -1;
    logic        hold = 1'b0;

    assign bcdu_ready = !hold;

    always @(posedge clk) begin
        if (rst) begin
            pend       <= 1'b0;
            bcdu_digit <= 4'h0;
            shift_no   <= 0;
        end else begin
            if (pend) begin
                bcdu_digit <= pend_digit;
                pend       <= 1'b0;
            end
            if (bcdu_valid && bcdu_ready) begin
                bcdu_digit <= 4'hE;
                pend       <= 1'b1;
                if (bcdu_instr[15:12] == 4'h1) begin
                    scratch    <= regs[bcdu_instr[7:4]];
                    shift_no   <= 0;
                    pend_digit <= 4'h0;
                end else begin
                    pend_digit <= (shift_no == inject_at) ? 4'hA : scratch[15:12];
                    scratch    <= scratch << 4;
                    shift_no   <= shift_no + 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    // exp_q entry: {latency[7:0] (0 = not checked), err, digits[15:0]}
    logic [24:0] exp_q [$];
    logic [15:0] instr_q [$];
    int          xfer_cnt = 0;
    int          done_cnt = 0;
    int          t_start  = 0;

    always @(negedge clk) begin
        logic [24:0] e;
        #1;
        if (!rst) begin
            if (bcdu_valid && bcdu_ready) begin
                xfer_cnt++;
                if (instr_q.size() == 0) fail_now("instr_unexpected");
                else check("instr", bcdu_instr, instr_q.pop_front());
            end
            if (err && !done) fail_now("err_without_done");
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    fail_now("done_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    check("digits", digits, e[15:0]);
                    check("err", err, e[16]);
                    check("busy_at_done", busy, 1);
                    check("xfers", xfer_cnt, 5);
                    if (e[24:17] != 8'd0) check("latency", cyc - t_start + 1, e[24:17]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_read(input logic [1:0] addr, input logic [15:0] exp_d, input logic exp_e,
                           input int exp_lat, input bit stall, input bit poke_busy,
                           input bit poke_finish);
        int          d0;
        bit          seen;
        logic [15:0] cw;
        cw = {4'h1, 4'h3, 2'b00, addr, 4'h0};
        exp_q.push_back({8'(exp_lat), exp_e, exp_d});
        instr_q.push_back(cw);
        repeat (4) instr_q.push_back(16'h4301);
        @(negedge clk);
        start    = 1'b1;
        src      = addr;
        xfer_cnt = 0;
        t_start  = cyc;
        d0       = done_cnt;
        if (stall) hold = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (stall) begin
            for (int i = 0; i < 6; i++) begin
                if (i > 0) @(negedge clk);
                check("stall_valid", bcdu_valid, 1);
                check("stall_instr", bcdu_instr, cw);
            end
            hold = 1'b0;
        end
        if (poke_busy) begin
            @(negedge clk);
            start = 1'b1;
            src   = 2'd2;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (done_cnt != d0) seen = 1;
        end
        if (!seen) fail_now("done_timeout");
        if (poke_finish) begin
            start = 1'b1;
            src   = addr;
            @(negedge clk);
            #2;
            start = 1'b0;
            check("finish_start_busy", busy, 0);
            check("finish_start_state", dbg_state, 0);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_mid_read(input logic [1:0] addr);
        int d0;
        bit seen;
        instr_q.push_back({4'h1, 4'h3, 2'b00, addr, 4'h0});
        repeat (4) instr_q.push_back(16'h4301);
        @(negedge clk);
        start    = 1'b1;
        src      = addr;
        xfer_cnt = 0;
        d0       = done_cnt;
        @(negedge clk);
        start = 1'b0;
        seen  = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (xfer_cnt == 3) seen = 1;
        end
        if (!seen) fail_now("second_shl_timeout");
        @(negedge clk);
        check("pre_rst_state", dbg_state, 4);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check("rst_state", dbg_state, 0);
        check("rst_valid", bcdu_valid, 0);
        check("rst_digits", digits, 16'hFFFF);
        check("rst_busy", busy, 0);
        check("rst_no_done", done_cnt, d0);
        rst = 1'b0;
        instr_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'h0;
        regs[0] = 16'h0000;
        regs[1] = 16'h1234;
        regs[2] = 16'h0050;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_valid", bcdu_valid, 0);
        check("reset_instr", bcdu_instr, 16'h0);
        check("reset_digits", digits, 16'hFFFF);
        check("reset_state", dbg_state, 0);
        rst = 1'b0;
        @(negedge clk);

        do_read(2'd1, 16'h1234, 1'b0, 17, 0, 0, 0);
        do_read(2'd2, 16'hFF50, 1'b0, 17, 0, 0, 1);
        do_read(2'd0, 16'hFFF0, 1'b0, 17, 0, 0, 0);
        inject_at = 2;
        do_read(2'd1, 16'h12F4, 1'b1, 17, 0, 0, 0);
        inject_at = -1;
        do_read(2'd1, 16'h1234, 1'b0, 22, 1, 1, 0);
        reset_mid_read(2'd1);
        do_read(2'd1, 16'h1234, 1'b0, 17, 0, 0, 0);
        regs[0] = 16'h0908;
        do_read(2'd0, 16'hF908, 1'b0, 17, 0, 0, 0);

        check("exp_q_empty", exp_q.size(), 0);
        check("instr_q_empty", instr_q.size(), 0);
        check("done_total", done_cnt, 7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
